// File: rtl/led_disp_arbiter.sv
// led_disp_arbiter: shares one 8-digit common-anode 7-segment display
// between two requesters. Round-robin grant with a minimum hold time while
// contended, then scans the owner's 8 BCD digits onto led_en / segments.
// Optional decimal-point inputs are enabled with `define LED_DISP_DP_EN.
module led_disp_arbiter #(
  parameter int SCAN_DIV = 100000,
  parameter int HOLD_MIN = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
`ifdef LED_DISP_DP_EN
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
`endif
  output logic [1:0]  grant,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MIN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        led_en_q, led_en_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              hold_done;
  logic [31:0]       cur_data;
  logic [3:0]        cur_nib;

  // BCD digit to active-low segments {a,b,c,d,e,f,g}; 10..15 are blank
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign hold_done = (hold_q == HOLD_LAST);

  // State register and round-robin memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: ownership transfer rules and last-owner bookkeeping
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                 state_d = req1 ? OWN1 : IDLE;
        else if (req1 && hold_done) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                 state_d = req0 ? OWN0 : IDLE;
        else if (req0 && hold_done) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_q == OWN0)      last_d = 1'b0;
      else if (state_q == OWN1) last_d = 1'b1;
    end
  end

  // Hold / scan / digit-index counters: restart on any ownership change
  always_comb begin
    hold_d = '0;
    scan_d = '0;
    idx_d  = '0;
    if ((state_d == state_q) && (state_q != IDLE)) begin
      hold_d = hold_done ? hold_q : hold_q + 1'b1;
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        idx_d  = idx_q + 3'd1;
      end else begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      hold_q <= hold_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  assign cur_data = (state_q == OWN1) ? data1 : data0;
  assign cur_nib  = cur_data[{idx_q, 2'b00} +: 4];

  // Output decode from current state; registered on the next edge
  always_comb begin
    led_en_d = '1;
    seg_d    = '1;
    dp_d     = 1'b1;
    if (state_q != IDLE) begin
      led_en_d        = '1;
      led_en_d[idx_q] = 1'b0;
      seg_d           = seg_decode(cur_nib);
`ifdef LED_DISP_DP_EN
      dp_d            = (state_q == OWN1) ? ~dp1[idx_q] : ~dp0[idx_q];
`endif
    end
  end

  // Display output registers: enables, segments and dp change together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en_q <= '1;
      seg_q    <= '1;
      dp_q     <= 1'b1;
    end else begin
      led_en_q <= led_en_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign grant  = state_q;
  assign led_en = led_en_q;
  assign {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg} = seg_q;

`ifdef LED_DISP_DP_EN
  assign led_dp = dp_q;
`else
  // dp is never driven low without the dp inputs; register left unused
  logic unused_dp;
  assign unused_dp = dp_q;
  assign led_dp    = 1'b1;
`endif

endmodule

// File: tb/tb_led_disp_arbiter.sv
// Self-checking bench for led_disp_arbiter (SCAN_DIV=4, HOLD_MIN=16).
// Model tracks owner and cycles-since-grant; digit and hold derive from that.
module tb_led_disp_arbiter;

  localparam int SD = 4;
  localparam int HM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic [7:0]  dp0, dp1;
  logic [1:0]  grant;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic [6:0]  seg_act;

  assign seg_act = {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg};

  always #5 clk = ~clk;

  led_disp_arbiter #(.SCAN_DIV(SD), .HOLD_MIN(HM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
`ifdef LED_DISP_DP_EN
    .dp0(dp0), .dp1(dp1),
`endif
    .grant(grant), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // Segment patterns {a..g} for digits 0..15
  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  // Model: owner 0=none, 1=req0, 2=req1; m_t = cycles since ownership began
  int         m_own, m_last, m_t;
  logic [1:0] exp_grant;
  logic [7:0] exp_en;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 1; m_t = 0;
    exp_grant = 2'b00; exp_en = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
  endtask

  task automatic model_step();
    logic        r [2];
    logic [31:0] dat;
    logic [7:0]  dpv;
    int          d, cur, oth, nxt;
    if (rst) begin
      model_reset();
      return;
    end
    r[0] = req0; r[1] = req1;
    if (m_own == 0) begin
      exp_en = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      d   = (m_t / SD) % 8;
      dat = (m_own == 1) ? data0 : data1;
      dpv = (m_own == 1) ? dp0 : dp1;
      exp_en = 8'hFF;
      exp_en[d] = 1'b0;
      exp_seg = seg_tab[4'((dat >> (4 * d)) & 32'hF)];
`ifdef LED_DISP_DP_EN
      exp_dp = ~dpv[d];
`else
      exp_dp = 1'b1;
`endif
    end
    nxt = m_own;
    if (m_own == 0) begin
      if (r[0] && r[1]) nxt = (m_last == 1) ? 1 : 2;
      else if (r[0])    nxt = 1;
      else if (r[1])    nxt = 2;
    end else begin
      cur = m_own - 1;
      oth = 1 - cur;
      if (!r[cur])                         nxt = r[oth] ? oth + 1 : 0;
      else if (r[oth] && m_t >= HM - 1)    nxt = oth + 1;
    end
    if (nxt != m_own) begin
      if (m_own != 0) m_last = m_own - 1;
      m_own = nxt;
      m_t = 0;
    end else if (m_own != 0) begin
      m_t++;
    end
    exp_grant = (m_own == 0) ? 2'b00 : ((m_own == 1) ? 2'b01 : 2'b10);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("grant", 32'(grant), 32'(exp_grant));
      check("led_en", 32'(led_en), 32'(exp_en));
      check("seg", 32'(seg_act), 32'(exp_seg));
      check("led_dp", 32'(led_dp), 32'(exp_dp));
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; dp0 = '0; dp1 = '0;
    model_reset();
    cmp_en = 1'b1;
    ticks(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_led_en", 32'(led_en), 32'hFF);
    check("rst_seg", 32'(seg_act), 32'h7F);

    // Single requester, full scan with wrap
    rst = 1'b0; req0 = 1'b1; data0 = 32'h76543210; dp0 = 8'h04;
    tick();
    check("first_grant", 32'(grant), 32'h1);
    tick();
    check("d0_en", 32'(led_en), 32'hFE);
    check("d0_seg", 32'(seg_act), 32'h01);
    ticks(8);
    check("d2_en", 32'(led_en), 32'hFB);
`ifdef LED_DISP_DP_EN
    check("d2_dp", 32'(led_dp), 32'h0);
`else
    check("d2_dp", 32'(led_dp), 32'h1);
`endif
    ticks(20);
    check("d7_en", 32'(led_en), 32'h7F);
    check("d7_seg", 32'(seg_act), 32'h0F);
    ticks(4);
    check("wrap_en", 32'(led_en), 32'hFE);
    dp0 = 8'h00;

    // Hold time: contender arrives at hold=3, switch after hold reaches 15
    req0 = 1'b0;
    tick();
    check("idle_grant", 32'(grant), 32'h0);
    req0 = 1'b1;
    ticks(4);
    req1 = 1'b1; data1 = 32'h89012345;
    ticks(12);
    check("hold_grant", 32'(grant), 32'h1);
    tick();
    check("switch_grant", 32'(grant), 32'h2);
    tick();
    check("sw_en", 32'(led_en), 32'hFE);
    check("sw_seg", 32'(seg_act), 32'h24);

    // Simultaneous requests from IDLE, then owner drops
    req0 = 1'b0; req1 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1; data1 = 32'h00000003;
    tick();
    check("tie_grant", 32'(grant), 32'h1);
    req0 = 1'b0;
    tick();
    check("drop_grant", 32'(grant), 32'h2);
    tick();
    check("drop_en", 32'(led_en), 32'hFE);
    check("drop_seg", 32'(seg_act), 32'h06);

    // Non-BCD nibbles blank the digit
    req1 = 1'b0; req0 = 1'b1; data0 = 32'hFFFFFFA9;
    tick();
    check("a9_grant", 32'(grant), 32'h1);
    tick();
    check("a9_d0_seg", 32'(seg_act), 32'h04);
    ticks(4);
    check("a9_d1_en", 32'(led_en), 32'hFD);
    check("a9_d1_seg", 32'(seg_act), 32'h7F);

    // Asynchronous reset in the middle of digit 5
    for (int i = 0; i < 64 && ((m_t / SD) % 8) != 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_en", 32'(led_en), 32'hFF);
    check("arst_seg", 32'(seg_act), 32'h7F);
    check("arst_grant", 32'(grant), 32'h0);
    model_reset();
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b1;
    tick();
    check("post_rst_grant", 32'(grant), 32'h2);

    // Randomised traffic with sticky requests and occasional reset
    for (int n = 0; n < 4000; n++) begin
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 9) == 0) req0 = ~req0;
      if ($urandom_range(0, 9) == 0) req1 = ~req1;
      if ($urandom_range(0, 15) == 0) data0 = $urandom;
      if ($urandom_range(0, 15) == 0) data1 = $urandom;
      if ($urandom_range(0, 15) == 0) dp0 = 8'($urandom);
      if ($urandom_range(0, 15) == 0) dp1 = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
